// File: rtl/axis_ofmap_drain_fifo.sv
// Ofmap drain FIFO: buffers whole MAC-array ofmap vectors and serialises each
// entry into 32-bit AXI4-Stream beats with tkeep on the partial final beat.

module axis_ofmap_drain_fifo_chk #(
    parameter int DRAIN_FIFO_DEPTH = 4,
    parameter int bit_num          = 2
) (
    input logic               clk,
    input logic               rst_n,
    input logic [bit_num-1:0] wr_ptr,
    input logic [bit_num-1:0] rd_ptr,
    input logic [bit_num:0]   cnt
);
    // Occupancy must match the pointer distance; full is the wrapped-equal case.
    a_cnt_ptr: assert property (@(posedge clk) disable iff (!rst_n)
        cnt[bit_num-1:0] == bit_num'(wr_ptr - rd_ptr));
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= (bit_num+1)'(DRAIN_FIFO_DEPTH));
endmodule

module axis_ofmap_drain_fifo #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int MAC_NUM              = 256,
    parameter int OFMAP_WIDTH          = 8,
    parameter int DRAIN_FIFO_DEPTH     = 4,
    parameter int bit_num              = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [OFMAP_WIDTH*MAC_NUM-1:0] ofmaps_in,
    input  logic                           ofmaps_valid,
    input  logic                           ofmaps_last,
    input  logic [11:0]                    output_channel_size,
    input  logic                           axis_clear,
    output logic [bit_num:0]               fifo_cnt,
    output logic                           fifo_full,
    output logic                           fifo_empty,
    output logic                           ofmaps_ready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [3:0]                     m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready
);
    localparam int DW     = OFMAP_WIDTH*MAC_NUM;
    localparam int SIZE_W = $clog2(MAC_NUM) + 1;
    localparam int BEAT_W = $clog2(MAC_NUM/4);

    logic [DW-1:0]     data_q [DRAIN_FIFO_DEPTH];
    logic [DW-1:0]     data_d [DRAIN_FIFO_DEPTH];
    logic [SIZE_W-1:0] size_q [DRAIN_FIFO_DEPTH];
    logic [SIZE_W-1:0] size_d [DRAIN_FIFO_DEPTH];
    logic              last_q [DRAIN_FIFO_DEPTH];
    logic              last_d [DRAIN_FIFO_DEPTH];
    logic [bit_num-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [bit_num:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;

    logic [DW-1:0]     head_data_s;
    logic [SIZE_W-1:0] head_size_s;
    logic [SIZE_W-1:0] n_beats_s;
    logic              final_beat_s;
    logic              pop_s;
    logic              pop_last_s;
    logic              write_en_s;

    function automatic logic [SIZE_W-1:0] clamp_size(input logic [11:0] sz);
        logic [SIZE_W-1:0] r;
        if (sz == 12'd0) begin
            r = SIZE_W'(1);
        end else if (sz > 12'(MAC_NUM)) begin
            r = SIZE_W'(MAC_NUM);
        end else begin
            r = sz[SIZE_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [3:0] beat_keep(input logic [SIZE_W-1:0] size, input logic is_final);
        logic [3:0] k;
        if (is_final) begin
            case (size[1:0])
                2'd1:    k = 4'b0001;
                2'd2:    k = 4'b0011;
                2'd3:    k = 4'b0111;
                default: k = 4'b1111;
            endcase
        end else begin
            k = 4'b1111;
        end
        return k;
    endfunction

    // Head-entry decode, handshake and write qualification.
    always_comb begin
        head_data_s   = data_q[rd_ptr_q];
        head_size_s   = size_q[rd_ptr_q];
        n_beats_s     = (head_size_s + SIZE_W'(3)) >> 2;
        final_beat_s  = ((SIZE_W'(beat_q) + SIZE_W'(1)) == n_beats_s);
        fifo_empty    = (cnt_q == (bit_num+1)'(0));
        fifo_full     = (cnt_q == (bit_num+1)'(DRAIN_FIFO_DEPTH));
        fifo_cnt      = cnt_q;
        m_axis_tvalid = ~fifo_empty;
        pop_s         = m_axis_tvalid & m_axis_tready;
        pop_last_s    = pop_s & final_beat_s;
        ofmaps_ready  = ~fifo_full | pop_last_s;
        write_en_s    = ofmaps_valid & ofmaps_ready;
        if (m_axis_tvalid) begin
            m_axis_tdata = head_data_s[{beat_q, 5'd0} +: C_M_AXIS_TDATA_WIDTH];
            m_axis_tkeep = beat_keep(head_size_s, final_beat_s);
            m_axis_tlast = final_beat_s & last_q[rd_ptr_q];
        end else begin
            m_axis_tdata = {C_M_AXIS_TDATA_WIDTH{1'b0}};
            m_axis_tkeep = 4'b0000;
            m_axis_tlast = 1'b0;
        end
    end

    // Pointer, occupancy and beat-index next state; clear overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        if (axis_clear) begin
            wr_ptr_d = {bit_num{1'b0}};
            rd_ptr_d = {bit_num{1'b0}};
            cnt_d    = {(bit_num+1){1'b0}};
            beat_d   = {BEAT_W{1'b0}};
        end else begin
            if (write_en_s) begin
                wr_ptr_d = wr_ptr_q + bit_num'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_last_s) begin
                beat_d   = {BEAT_W{1'b0}};
                rd_ptr_d = rd_ptr_q + bit_num'(1);
            end else if (pop_s) begin
                beat_d   = beat_q + BEAT_W'(1);
            end else begin
                beat_d   = beat_q;
            end
            case ({write_en_s, pop_last_s})
                2'b10:   cnt_d = cnt_q + (bit_num+1)'(1);
                2'b01:   cnt_d = cnt_q - (bit_num+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Entry storage: a write captures the full vector, clamped size and last flag.
    always_comb begin
        data_d = data_q;
        size_d = size_q;
        last_d = last_q;
        if (write_en_s && !axis_clear) begin
            data_d[wr_ptr_q] = ofmaps_in;
            size_d[wr_ptr_q] = clamp_size(output_channel_size);
            last_d[wr_ptr_q] = ofmaps_last;
        end else begin
            data_d[wr_ptr_q] = data_q[wr_ptr_q];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {bit_num{1'b0}};
            rd_ptr_q <= {bit_num{1'b0}};
            cnt_q    <= {(bit_num+1){1'b0}};
            beat_q   <= {BEAT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
        end
    end

    // Entry storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DRAIN_FIFO_DEPTH; i++) begin
                data_q[i] <= {DW{1'b0}};
                size_q[i] <= {SIZE_W{1'b0}};
                last_q[i] <= 1'b0;
            end
        end else begin
            data_q <= data_d;
            size_q <= size_d;
            last_q <= last_d;
        end
    end

    axis_ofmap_drain_fifo_chk #(
        .DRAIN_FIFO_DEPTH(DRAIN_FIFO_DEPTH),
        .bit_num         (bit_num)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_ptr(wr_ptr_q),
        .rd_ptr(rd_ptr_q),
        .cnt   (cnt_q)
    );
endmodule

// File: tb/tb_axis_ofmap_drain_fifo.sv
// Randomised bench for axis_ofmap_drain_fifo against a beat-queue reference model.

module tb_axis_ofmap_drain_fifo;
    localparam int MAC = 256;
    localparam int DW  = MAC*8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] ofmaps_in = '0;
    logic          ofmaps_valid = 1'b0;
    logic          ofmaps_last = 1'b0;
    logic [11:0]   output_channel_size = 12'd0;
    logic          axis_clear = 1'b0;
    logic [2:0]    fifo_cnt;
    logic          fifo_full, fifo_empty, ofmaps_ready;
    logic [31:0]   m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tlast, m_axis_tvalid;
    logic          m_axis_tready = 1'b0;

    axis_ofmap_drain_fifo dut (
        .clk(clk), .rst_n(rst_n), .ofmaps_in(ofmaps_in), .ofmaps_valid(ofmaps_valid),
        .ofmaps_last(ofmaps_last), .output_channel_size(output_channel_size),
        .axis_clear(axis_clear), .fifo_cnt(fifo_cnt), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .ofmaps_ready(ofmaps_ready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        f;
    } beat_t;

    beat_t q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    hs_cnt = 0;
    logic  acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        foreach (q[i]) if (q[i].f) c++;
        return c;
    endfunction

    // Expand one written vector into its expected beats.
    task automatic push_entry(input logic [11:0] sz, input logic lst);
        int eff, n;
        beat_t b;
        eff = (sz == 12'd0) ? 1 : ((int'(sz) > MAC) ? MAC : int'(sz));
        n   = (eff + 3) / 4;
        for (int k = 0; k < n; k++) begin
            b.d = ofmaps_in[32*k +: 32];
            b.f = (k == n-1);
            b.l = b.f && lst;
            b.k = (b.f && (eff % 4 != 0)) ? 4'((1 << (eff % 4)) - 1) : 4'hF;
            q.push_back(b);
        end
    endtask

    task automatic cycle(input logic v, input logic [11:0] sz, input logic lst,
                         input logic rdy, input logic clr);
        int   cnt_e;
        logic pop_fin, rdy_e;
        ofmaps_valid = v; output_channel_size = sz; ofmaps_last = lst;
        m_axis_tready = rdy; axis_clear = clr;
        if (v) for (int w = 0; w < MAC/4; w++) ofmaps_in[32*w +: 32] = $urandom;
        @(negedge clk);
        cnt_e = model_cnt();
        chk("fifo_cnt", 64'(fifo_cnt), 64'(cnt_e));
        chk("fifo_empty", 64'(fifo_empty), 64'(cnt_e == 0));
        chk("fifo_full", 64'(fifo_full), 64'(cnt_e == 4));
        chk("tvalid", 64'(m_axis_tvalid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("tdata", 64'(m_axis_tdata), 64'(q[0].d));
            chk("tkeep", 64'(m_axis_tkeep), 64'(q[0].k));
            chk("tlast", 64'(m_axis_tlast), 64'(q[0].l));
        end
        pop_fin = (q.size() > 0) && rdy && q[0].f;
        rdy_e   = (cnt_e < 4) || pop_fin;
        chk("ofmaps_ready", 64'(ofmaps_ready), 64'(rdy_e));
        acc = 1'b0;
        if (clr) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) begin
                void'(q.pop_front());
                hs_cnt++;
            end
            if (v && rdy_e) begin
                acc = 1'b1;
                push_entry(sz, lst);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && q.size() > 0; i++) cycle(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
        chk("drain_timeout", 64'(q.size()), 64'd0);
        cycle(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
        chk({tag, "_tkeep"},  64'(m_axis_tkeep),  64'd0);
        chk({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
        chk({tag, "_empty"},  64'(fifo_empty),    64'd1);
        chk({tag, "_full"},   64'(fifo_full),     64'd0);
        chk({tag, "_ready"},  64'(ofmaps_ready),  64'd1);
        chk({tag, "_cnt"},    64'(fifo_cnt),      64'd0);
    endtask

    initial begin
        int wrote;
        @(posedge clk); #1;
        reset_checks("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full-width entry: 64 beats, tlast only on the final one.
        hs_cnt = 0;
        cycle(1'b1, 12'd256, 1'b1, 1'b1, 1'b0);
        drain(100);
        chk("t1_beats", 64'(hs_cnt), 64'd64);

        // Partial final beats and size clamping.
        cycle(1'b1, 12'd10, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 12'd10, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 12'd0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 12'd3001, 1'b1, 1'b1, 1'b0);
        drain(200);

        // Fill, refuse, then write on the final-beat pop cycle across the wrap.
        for (int i = 0; i < 4; i++) cycle(1'b1, 12'd8, 1'(i), 1'b0, 1'b0);
        cycle(1'b1, 12'd8, 1'b1, 1'b0, 1'b0);
        chk("t3_refused", 64'(acc), 64'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 12'd8, 1'b1, 1'b1, 1'b0);
        drain(100);

        // Random backpressure over 8 entries of 16 channels.
        hs_cnt = 0;
        wrote  = 0;
        for (int i = 0; i < 500 && (wrote < 8 || q.size() > 0); i++) begin
            cycle(1'(wrote < 8), 12'd16, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if (acc) wrote++;
        end
        chk("t4_entries", 64'(wrote), 64'd8);
        chk("t4_handshakes", 64'(hs_cnt), 64'd32);

        // Clear mid-entry with three entries held.
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'd256, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
        chk("t5_cnt_before", 64'(fifo_cnt), 64'd3);
        cycle(1'b1, 12'd256, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'd12, 1'b1, 1'b1, 1'b0);
        drain(50);

        // Asynchronous reset mid-stream.
        cycle(1'b1, 12'd256, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
        ofmaps_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_checks("amid");
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 12'd20, 1'b1, 1'b1, 1'b0);
        drain(50);

        // Random sizes, valids and backpressure.
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 1)), 12'($urandom_range(0, 300)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
        drain(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
